mem_bus_arbiter: RTL and testbench

Parametrised N-port arbiter and router between cache-side requesters (icache, dcache, and future ports such as a page-table walker) and the single core memory bus. It replaces the current fixed two-way latch-based priority mux with a registered request stage, fixed or round-robin arbitration, and ready/valid backpressure toward memory. It also counts outstanding reads per port and routes responses back by ID.

---
 rtl/mem_bus_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   N-port arbiter between cache-side requesters and the single core memory
//   bus. A registered request stage presents one request at a time to memory
//   with ready/valid backpressure; arbitration is fixed priority or
//   round-robin. Outstanding reads are counted per port and responses are
//   routed back by ID.
// Ports:
//   clock, reset               system clock, synchronous active-high reset
//   req_read/req_write         per-port request strobes, held until granted
//   req_addr/req_data          per-port request fields, packed by port index
//   req_grant                  one-hot pulse: port's request accepted
//   resp_valid/addr/data       routed response strobe, broadcast addr/data
//   mem_req_*                  registered request toward memory
//   mem_resp_*                 response from memory
//   port_full                  per-port outstanding-read count at limit
//   err_bad_resp               sticky illegal-response flag
module mem_bus_arbiter #(
  parameter int unsigned NUM_PORTS       = 2,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 128,
  parameter int unsigned ARB_MODE        = 0,
  parameter int unsigned MAX_OUTSTANDING = 2,
  localparam int unsigned ID_WIDTH       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_PORTS-1:0]            req_read,
  input  logic [NUM_PORTS-1:0]            req_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_data,
  output logic [NUM_PORTS-1:0]            req_grant,
  output logic [NUM_PORTS-1:0]            resp_valid,
  output logic [ADDR_WIDTH-1:0]           resp_addr,
  output logic [DATA_WIDTH-1:0]           resp_data,
  output logic                            mem_req_valid,
  input  logic                            mem_req_ready,
  output logic                            mem_req_read,
  output logic                            mem_req_write,
  output logic [ID_WIDTH-1:0]             mem_req_id,
  output logic [ADDR_WIDTH-1:0]           mem_req_addr,
  output logic [DATA_WIDTH-1:0]           mem_req_data,
  input  logic                            mem_resp_valid,
  input  logic [ID_WIDTH-1:0]             mem_resp_id,
  input  logic [ADDR_WIDTH-1:0]           mem_resp_addr,
  input  logic [DATA_WIDTH-1:0]           mem_resp_data,
  output logic [NUM_PORTS-1:0]            port_full,
  output logic                            err_bad_resp
);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e                  state_q, state_d;
  logic                    valid_q, valid_d;
  logic                    read_q, read_d;
  logic                    write_q, write_d;
  logic [ID_WIDTH-1:0]     id_q, id_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [ID_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;
  logic [3:0]              cnt_q [NUM_PORTS];
  logic [3:0]              cnt_d [NUM_PORTS];
  logic                    err_q, err_d;

  logic [NUM_PORTS-1:0]    is_read;
  logic [NUM_PORTS-1:0]    eligible;
  logic                    win_valid;
  logic [ID_WIDTH-1:0]     win_id;
  logic                    grant_fire;

  // A write wins over a simultaneous read; only pure reads are throttled.
  always_comb begin
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      port_full[i] = (cnt_q[i] == 4'(MAX_OUTSTANDING));
      is_read[i]   = req_read[i] & ~req_write[i];
      eligible[i]  = (req_read[i] | req_write[i]) & ~(is_read[i] & port_full[i]);
    end
  end

  // Priority search starts at index 0 (fixed) or at the rotating pointer.
  always_comb begin
    int unsigned start;
    int unsigned idx;
    win_valid = 1'b0;
    win_id    = '0;
    start     = (ARB_MODE == 1) ? 32'(rr_ptr_q) : 0;
    for (int unsigned off = 0; off < NUM_PORTS; off++) begin
      idx = (start + off) % NUM_PORTS;
      if (!win_valid && eligible[idx]) begin
        win_valid = 1'b1;
        win_id    = ID_WIDTH'(idx);
      end
    end
  end

  // The output register can take a new request when empty or being drained.
  assign grant_fire = !reset && win_valid && (state_q == IDLE || mem_req_ready);
  assign rr_ptr_d   = grant_fire ? ID_WIDTH'((32'(win_id) + 1) % NUM_PORTS) : rr_ptr_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_fire) state_d = HOLD;
      HOLD:    if (mem_req_ready && !grant_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_grant = '0;
    valid_d   = valid_q;
    read_d    = read_q;
    write_d   = write_q;
    id_d      = id_q;
    addr_d    = addr_q;
    data_d    = data_q;
    if (grant_fire) begin
      req_grant[win_id] = 1'b1;
      valid_d           = 1'b1;
      read_d            = is_read[win_id];
      write_d           = req_write[win_id];
      id_d              = win_id;
      addr_d            = req_addr[win_id*ADDR_WIDTH +: ADDR_WIDTH];
      data_d            = req_data[win_id*DATA_WIDTH +: DATA_WIDTH];
    end else if (state_q == HOLD && mem_req_ready) begin
      valid_d = 1'b0;
      read_d  = 1'b0;
      write_d = 1'b0;
    end
  end

  // Responses only route to a port that actually has a read in flight.
  always_comb begin
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      resp_valid[i] = mem_resp_valid && (mem_resp_id == ID_WIDTH'(i)) && (cnt_q[i] != 4'd0);
      cnt_d[i]      = cnt_q[i];
      case ({req_grant[i] & is_read[i], resp_valid[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + 4'd1;
        2'b01:   cnt_d[i] = cnt_q[i] - 4'd1;
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
    err_d = err_q | (mem_resp_valid && (resp_valid == '0));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q  <= 1'b0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      id_q     <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) cnt_q[i] <= '0;
    end else begin
      valid_q  <= valid_d;
      read_q   <= read_d;
      write_q  <= write_d;
      id_q     <= id_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
      for (int unsigned i = 0; i < NUM_PORTS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign mem_req_valid = valid_q;
  assign mem_req_read  = read_q;
  assign mem_req_write = write_q;
  assign mem_req_id    = id_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_data  = data_q;
  assign resp_addr     = mem_resp_addr;
  assign resp_data     = mem_resp_data;
  assign err_bad_resp  = err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a 3-port fixed-priority instance and a
// 4-port round-robin instance share clock and reset.
module tb_mem_bus_arbiter;

  logic clock;
  logic reset;

  // fixed priority, 3 ports, ID width 2
  logic [2:0]  f_req_read, f_req_write, f_req_grant, f_resp_valid, f_port_full;
  logic [95:0] f_req_addr, f_req_data;
  logic [31:0] f_resp_addr, f_resp_data, f_mreq_addr, f_mreq_data, f_mresp_addr, f_mresp_data;
  logic        f_mreq_valid, f_mreq_ready, f_mreq_read, f_mreq_write, f_mresp_valid, f_err;
  logic [1:0]  f_mreq_id, f_mresp_id;

  // round-robin, 4 ports, ID width 2
  logic [3:0]   r_req_read, r_req_write, r_req_grant, r_resp_valid, r_port_full;
  logic [127:0] r_req_addr, r_req_data;
  logic [31:0]  r_resp_addr, r_resp_data, r_mreq_addr, r_mreq_data, r_mresp_addr, r_mresp_data;
  logic         r_mreq_valid, r_mreq_ready, r_mreq_read, r_mreq_write, r_mresp_valid, r_err;
  logic [1:0]   r_mreq_id, r_mresp_id;

  int checks = 0;
  int errors = 0;

  mem_bus_arbiter #(.NUM_PORTS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(0),
                    .MAX_OUTSTANDING(2)) u_fix (
    .clock(clock), .reset(reset),
    .req_read(f_req_read), .req_write(f_req_write), .req_addr(f_req_addr), .req_data(f_req_data),
    .req_grant(f_req_grant), .resp_valid(f_resp_valid), .resp_addr(f_resp_addr), .resp_data(f_resp_data),
    .mem_req_valid(f_mreq_valid), .mem_req_ready(f_mreq_ready), .mem_req_read(f_mreq_read),
    .mem_req_write(f_mreq_write), .mem_req_id(f_mreq_id), .mem_req_addr(f_mreq_addr),
    .mem_req_data(f_mreq_data), .mem_resp_valid(f_mresp_valid), .mem_resp_id(f_mresp_id),
    .mem_resp_addr(f_mresp_addr), .mem_resp_data(f_mresp_data), .port_full(f_port_full),
    .err_bad_resp(f_err)
  );

  mem_bus_arbiter #(.NUM_PORTS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(1),
                    .MAX_OUTSTANDING(2)) u_rr (
    .clock(clock), .reset(reset),
    .req_read(r_req_read), .req_write(r_req_write), .req_addr(r_req_addr), .req_data(r_req_data),
    .req_grant(r_req_grant), .resp_valid(r_resp_valid), .resp_addr(r_resp_addr), .resp_data(r_resp_data),
    .mem_req_valid(r_mreq_valid), .mem_req_ready(r_mreq_ready), .mem_req_read(r_mreq_read),
    .mem_req_write(r_mreq_write), .mem_req_id(r_mreq_id), .mem_req_addr(r_mreq_addr),
    .mem_req_data(r_mreq_data), .mem_resp_valid(r_mresp_valid), .mem_resp_id(r_mresp_id),
    .mem_resp_addr(r_mresp_addr), .mem_resp_data(r_mresp_data), .port_full(r_port_full),
    .err_bad_resp(r_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle;
    @(posedge clock);
    #1;
  endtask

  task automatic sample;
    @(negedge clock);
  endtask

  initial begin
    logic [3:0] exp_g;
    int         pid;

    reset = 1'b1;
    f_req_read = '0; f_req_write = '0; f_req_addr = '0; f_req_data = '0;
    f_mreq_ready = 1'b0; f_mresp_valid = 1'b0; f_mresp_id = '0;
    f_mresp_addr = '0; f_mresp_data = '0;
    r_req_read = '0; r_req_write = '0; r_req_addr = '0; r_req_data = '0;
    r_mreq_ready = 1'b0; r_mresp_valid = 1'b0; r_mresp_id = '0;
    r_mresp_addr = '0; r_mresp_data = '0;
    next_cycle;
    next_cycle;
    reset = 1'b0;
    sample;
    check("rst_valid", 64'(f_mreq_valid), 64'd0);
    check("rst_full", 64'(f_port_full), 64'd0);
    check("rst_err", 64'(f_err), 64'd0);
    check("rst_rr_valid", 64'(r_mreq_valid), 64'd0);

    // two simultaneous reads, fixed priority, back-to-back
    next_cycle;
    f_mreq_ready = 1'b1;
    f_req_addr[31:0]  = 32'h100;
    f_req_addr[63:32] = 32'h200;
    f_req_read = 3'b011;
    sample;
    check("t1_grant0", 64'(f_req_grant), 64'b001);
    next_cycle;
    f_req_read = 3'b010;
    sample;
    check("t1_grant1", 64'(f_req_grant), 64'b010);
    check("t1_valid0", 64'(f_mreq_valid), 64'd1);
    check("t1_id0", 64'(f_mreq_id), 64'd0);
    check("t1_addr0", 64'(f_mreq_addr), 64'h100);
    check("t1_read0", 64'(f_mreq_read), 64'd1);
    next_cycle;
    f_req_read = 3'b000;
    sample;
    check("t1_nogrant", 64'(f_req_grant), 64'd0);
    check("t1_id1", 64'(f_mreq_id), 64'd1);
    check("t1_addr1", 64'(f_mreq_addr), 64'h200);
    next_cycle;
    sample;
    check("t1_idle", 64'(f_mreq_valid), 64'd0);

    // port 0 (one read in flight) reaches the limit
    next_cycle;
    f_req_read = 3'b001;
    sample;
    check("t4_grant2nd", 64'(f_req_grant), 64'b001);
    check("t4_notfull", 64'(f_port_full), 64'b000);
    next_cycle;
    sample;
    check("t4_full", 64'(f_port_full), 64'b001);
    check("t4_blocked", 64'(f_req_grant), 64'd0);
    next_cycle;
    sample;
    check("t4_blocked_idle", 64'(f_req_grant), 64'd0);
    check("t4_valid_low", 64'(f_mreq_valid), 64'd0);
    next_cycle;
    f_mresp_valid = 1'b1; f_mresp_id = 2'd0;
    f_mresp_addr = 32'hAA; f_mresp_data = 32'h55;
    sample;
    check("t4_resp_valid", 64'(f_resp_valid), 64'b001);
    check("t4_resp_addr", 64'(f_resp_addr), 64'hAA);
    check("t4_resp_data", 64'(f_resp_data), 64'h55);
    next_cycle;
    f_mresp_valid = 1'b0;
    sample;
    check("t4_grant3rd", 64'(f_req_grant), 64'b001);
    check("t4_freed", 64'(f_port_full), 64'b000);
    next_cycle;
    f_req_read = 3'b000;
    sample;
    check("t4_req3_read", 64'(f_mreq_read), 64'd1);
    next_cycle;

    // port 1 (count 1): read grant and response in the same cycle
    f_req_read = 3'b010;
    f_mresp_valid = 1'b1; f_mresp_id = 2'd1;
    sample;
    check("t5_grant", 64'(f_req_grant), 64'b010);
    check("t5_resp", 64'(f_resp_valid), 64'b010);
    next_cycle;
    f_mresp_valid = 1'b0;
    sample;
    check("t5_count_kept", 64'(f_port_full), 64'b001);
    check("t5_grant_again", 64'(f_req_grant), 64'b010);
    next_cycle;
    f_req_read = 3'b000;
    sample;
    check("t5_full_now", 64'(f_port_full), 64'b011);
    next_cycle;

    // read+write on a full port is a write: eligible, not counted
    f_req_read = 3'b001; f_req_write = 3'b001;
    f_req_data[31:0] = 32'hCAFE;
    sample;
    check("rw_grant", 64'(f_req_grant), 64'b001);
    next_cycle;
    f_req_read = 3'b000; f_req_write = 3'b000;
    sample;
    check("rw_read", 64'(f_mreq_read), 64'd0);
    check("rw_write", 64'(f_mreq_write), 64'd1);
    check("rw_data", 64'(f_mreq_data), 64'hCAFE);
    check("rw_full", 64'(f_port_full), 64'b011);
    next_cycle;

    // backpressure: port 2 write held for 5 cycles
    f_mreq_ready = 1'b0;
    f_req_write = 3'b100;
    f_req_addr[95:64] = 32'h1000;
    f_req_data[95:64] = 32'hD00D;
    sample;
    check("t3_grant", 64'(f_req_grant), 64'b100);
    next_cycle;
    f_req_addr[95:64] = 32'h2000;
    for (int k = 0; k < 5; k++) begin
      sample;
      check("t3_hold_valid", 64'(f_mreq_valid), 64'd1);
      check("t3_hold_addr", 64'(f_mreq_addr), 64'h1000);
      check("t3_hold_data", 64'(f_mreq_data), 64'hD00D);
      check("t3_hold_id", 64'(f_mreq_id), 64'd2);
      check("t3_hold_wr", 64'(f_mreq_write), 64'd1);
      check("t3_no_grant", 64'(f_req_grant), 64'd0);
      next_cycle;
    end
    f_mreq_ready = 1'b1;
    sample;
    check("t3_hs_addr", 64'(f_mreq_addr), 64'h1000);
    check("t3_b2b_grant", 64'(f_req_grant), 64'b100);
    next_cycle;
    f_req_write = 3'b000;
    sample;
    check("t3_second_addr", 64'(f_mreq_addr), 64'h2000);
    check("t3_second_nogrant", 64'(f_req_grant), 64'd0);
    next_cycle;
    sample;
    check("t3_idle", 64'(f_mreq_valid), 64'd0);

    // response to a port with nothing outstanding
    check("t6_err_clear", 64'(f_err), 64'd0);
    next_cycle;
    f_mresp_valid = 1'b1; f_mresp_id = 2'd2;
    sample;
    check("t6_zero_resp", 64'(f_resp_valid), 64'd0);
    next_cycle;
    f_mresp_valid = 1'b0;
    sample;
    check("t6_err_set", 64'(f_err), 64'd1);
    next_cycle;
    sample;
    check("t6_err_sticky", 64'(f_err), 64'd1);

    // reset while holding a request
    next_cycle;
    f_mreq_ready = 1'b0;
    f_req_write = 3'b100;
    sample;
    check("rh_grant", 64'(f_req_grant), 64'b100);
    next_cycle;
    reset = 1'b1;
    sample;
    check("rh_grant_in_reset", 64'(f_req_grant), 64'd0);
    check("rh_valid_pre", 64'(f_mreq_valid), 64'd1);
    next_cycle;
    reset = 1'b0;
    f_req_write = 3'b000;
    sample;
    check("rh_valid_cleared", 64'(f_mreq_valid), 64'd0);
    check("rh_counters", 64'(f_port_full), 64'd0);
    check("rh_err_cleared", 64'(f_err), 64'd0);

    // out-of-range response id
    next_cycle;
    f_mreq_ready = 1'b1;
    f_mresp_valid = 1'b1; f_mresp_id = 2'd3;
    sample;
    check("t6_id3_resp", 64'(f_resp_valid), 64'd0);
    next_cycle;
    f_mresp_valid = 1'b0;
    sample;
    check("t6_id3_err", 64'(f_err), 64'd1);

    // round-robin: all four ports write continuously
    next_cycle;
    r_mreq_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      r_req_addr[i*32 +: 32] = 32'(32'h100 * i);
      r_req_data[i*32 +: 32] = 32'(32'h1000 + i);
    end
    r_req_write = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      sample;
      exp_g = 4'(1 << (c % 4));
      check("rr_grant", 64'(r_req_grant), 64'(exp_g));
      if (c >= 1) begin
        pid = (c - 1) % 4;
        check("rr_valid", 64'(r_mreq_valid), 64'd1);
        check("rr_id", 64'(r_mreq_id), 64'(pid));
        check("rr_data", 64'(r_mreq_data), 64'(32'h1000 + pid));
        check("rr_addr", 64'(r_mreq_addr), 64'(32'h100 * pid));
        check("rr_write", 64'(r_mreq_write), 64'd1);
      end
      next_cycle;
    end
    r_req_write = 4'b0000;
    sample;
    check("rr_last_id", 64'(r_mreq_id), 64'd1);
    next_cycle;
    next_cycle;
    // pointer sits at 2: between ports 1 and 3, port 3 comes first
    r_req_write = 4'b1010;
    sample;
    check("rr_ptr_grant3", 64'(r_req_grant), 64'b1000);
    next_cycle;
    r_req_write = 4'b0010;
    sample;
    check("rr_id3", 64'(r_mreq_id), 64'd3);
    check("rr_wrap_grant1", 64'(r_req_grant), 64'b0010);
    next_cycle;
    r_req_write = 4'b0000;
    r_mresp_addr = 32'h77; r_mresp_data = 32'h88;
    sample;
    check("rr_id1", 64'(r_mreq_id), 64'd1);
    check("rr_no_count", 64'(r_port_full), 64'd0);
    check("rr_read_low", 64'(r_mreq_read), 64'd0);
    check("rr_resp_none", 64'(r_resp_valid), 64'd0);
    check("rr_resp_addr", 64'(r_resp_addr), 64'h77);
    check("rr_resp_data", 64'(r_resp_data), 64'h88);
    check("rr_err", 64'(r_err), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
